// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using one full-adder slice and one carry flop.
// Operands are captured on an accepted start and added LSB-first, one bit per clock.
// The registered sum/cout update together with a one-cycle done pulse.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   a, b  - operands, captured on the accept edge
//   busy  - high whenever an operation is in flight (ADD or DONE)
//   done  - one-cycle pulse; sum/cout valid from this cycle on
//   sum   - registered (a + b) mod 2^WIDTH
//   cout  - registered carry-out
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // One extra bit so cnt never wraps within an operation.
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAdd,
      StDone
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             s;
   logic             c_next;
   logic [WIDTH-1:0] acc_next;

   // Full-adder slice on the current LSBs; acc_next includes the bit produced this cycle.
   always_comb begin
      s               = sa[0] ^ sb[0] ^ c;
      c_next          = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
      acc_next        = acc >> 1;
      acc_next[WIDTH-1] = s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StIdle;
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  acc   <= '0;
                  c     <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= StAdd;
               end
            end
            StAdd: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               acc <= acc_next;
               c   <= c_next;
               cnt <= cnt + 1'b1;
               if (cnt == LastBit) begin
                  // Publish the complete result, including the bit computed on this edge.
                  sum   <= acc_next;
                  cout  <= c_next;
                  done  <= 1'b1;
                  state <= StDone;
               end
            end
            StDone: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start2, busy2, done2, cout2;
   logic [1:0] a2, b2, sum2;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Result the 8-bit DUT should currently be holding.
   logic [8:0] exp_prev = '0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition of the operands.
   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

   task automatic add8(input string name, input logic [7:0] x, input logic [7:0] y,
                       input logic [8:0] exp);
      int lat;
      int busy_n;
      bit held;
      @(negedge clk);
      for (int i = 0; i < 40 && busy8; i++) @(negedge clk);
      a8 = x; b8 = y; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8 = ~x; b8 = 8'($urandom);  // must not disturb the in-flight add
      lat = 0; busy_n = 0; held = 1'b1;
      while (!done8 && lat < 50) begin
         if (busy8) busy_n++;
         if ({cout8, sum8} !== exp_prev) held = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (busy8) busy_n++;
      check({name, " latency"}, lat, 8);
      check({name, " busy cycles"}, busy_n, 9);
      check({name, " prior result held"}, {31'd0, held}, 1);
      check({name, " result"}, {23'd0, cout8, sum8}, {23'd0, exp});
      @(posedge clk);
      #1;
      check({name, " idle after done"}, {30'd0, done8, busy8}, 0);
      check({name, " result kept"}, {23'd0, cout8, sum8}, {23'd0, exp});
      exp_prev = exp;
   endtask

   task automatic add2(input logic [1:0] x, input logic [1:0] y);
      int lat;
      @(negedge clk);
      for (int i = 0; i < 20 && busy2; i++) @(negedge clk);
      a2 = x; b2 = y; start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check($sformatf("w2 %0d+%0d latency", x, y), lat, 2);
      check($sformatf("w2 %0d+%0d result", x, y), {29'd0, cout2, sum2},
            32'(x) + 32'(y));
   endtask

   initial begin
      int   ndone;
      int   k;
      logic b9, b10;
      logic [8:0] r8;
      logic [7:0] x, y;

      vecs[0] = '{8'h00, 8'h00, 9'h000};
      vecs[1] = '{8'hFF, 8'h01, 9'h100};
      vecs[2] = '{8'hA5, 8'h5A, 9'h0FF};
      vecs[3] = '{8'hFF, 8'hFF, 9'h1FE};
      vecs[4] = '{8'h12, 8'h34, 9'h046};  // back-to-back after FF+FF
      vecs[5] = '{8'h80, 8'h80, 9'h100};
      vecs[6] = '{8'h7F, 8'h01, 9'h080};
      vecs[7] = '{8'h3C, 8'hC3, 9'h0FF};

      rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
      start2 = 1'b0; a2 = '0; b2 = '0;
      #12;
      check("reset outputs w8", {21'd0, busy8, done8, cout8, sum8}, 0);
      check("reset outputs w2", {27'd0, busy2, done2, cout2, sum2}, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         add8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

      // start held high through the whole operation, operands changing mid-add
      @(negedge clk);
      for (int i = 0; i < 40 && busy8; i++) @(negedge clk);
      a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h55;
      ndone = 0; b9 = 1'b1; b10 = 1'b0; r8 = '0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (done8) begin
            ndone++;
            r8 = {cout8, sum8};
         end
         if (i == 9) b9 = busy8;
         if (i == 10) b10 = busy8;
      end
      start8 = 1'b0;
      check("held start done count", ndone, 1);
      check("held start result", {23'd0, r8}, 32'h010);
      check("held start idle between ops", {31'd0, b9}, 0);
      check("held start restart from idle", {31'd0, b10}, 1);
      k = 0;
      while (!done8 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("held start second result", {23'd0, cout8, sum8}, {23'd0, model8(8'h55, 8'h55)});
      exp_prev = model8(8'h55, 8'h55);

      // asynchronous reset while bit 4 is being processed
      @(negedge clk);
      for (int i = 0; i < 40 && busy8; i++) @(negedge clk);
      a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async reset clears outputs", {21'd0, busy8, done8, cout8, sum8}, 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done8) ndone++;
      end
      check("no done after abort", ndone, 0);
      check("outputs stay clear after abort", {22'd0, busy8, cout8, sum8}, 0);
      exp_prev = '0;
      add8("post-reset 03+04", 8'h03, 8'h04, 9'h007);

      for (int i = 0; i < 30; i++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         add8($sformatf("rand %02h+%02h", x, y), x, y, model8(x, y));
      end

      for (int i = 0; i < 16; i++) add2(2'(i >> 2), 2'(i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the half-adder pair plus one carry flop.
- Captures two operands on a start request and adds them LSB-first, one bit per clock.
- Delivers a registered sum and carry-out with a one-cycle done pulse.
- Sits downstream of the combinational half adder and replaces a wide ripple chain where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range WIDTH >= 1).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle on.
- sum  output  WIDTH  registered result (a + b) mod 2^WIDTH.
- cout  output  1  registered carry-out of the addition.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: rst asserted at any time forces the following immediately, without waiting for a clock edge.
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, carry flop and bit counter = 0.
- States are IDLE, ADD and DONE.
- IDLE:
  - start = 1 at edge E0 loads a and b into shift registers sa and sb, clears carry c, and clears counter cnt to 0.
  - The same edge moves the state to ADD.
  - start = 0 keeps the state in IDLE.
- ADD, at each edge:
  - s = sa[0] ^ sb[0] ^ c.
  - c <= (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0])).
  - sa and sb shift right by 1.
  - Accumulator acc shifts right with s inserted at acc[WIDTH-1].
  - cnt increments by 1.
- ADD exit: on the edge where cnt == WIDTH-1 (the WIDTH-th bit), the block does all of the following.
  - Moves to DONE.
  - Loads sum with the final accumulator value, including that last bit.
  - Loads cout with the final carry.
- DONE:
  - Lasts exactly one cycle with done = 1, then returns to IDLE unconditionally.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH clock edges after the start-accept edge E0.
- Throughput: one addition per WIDTH+2 cycles.
  - The earliest next start is accepted on the edge that ends DONE+1, i.e. the first cycle back in IDLE.
- start while busy: start is ignored in ADD and DONE; no queuing, and in-flight operands are unaffected.
- Operand changes on a and b after the accept edge have no effect.
- sum/cout hold their value from the DONE entry edge until the next completed operation or reset; they never show partial results.
- done is never asserted twice per accepted start, and never asserted without a start.
- Reset mid-operation aborts the add: no done pulse, sum/cout = 0, and the next start behaves as after power-up.
- WIDTH = 1: ADD lasts one cycle, and the block behaves as a registered full adder with c_in = 0.
- cnt width is $clog2(WIDTH)+1 so that cnt never wraps within an operation.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, pulse start -> busy for 9 cycles; done pulses 8 edges after accept; sum=0x00, cout=0.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple); a=0xA5, b=0x5A -> sum=0xFF, cout=0.
- WIDTH=8, a=0xFF, b=0xFF -> sum=0xFE, cout=1; then a back-to-back start in the first IDLE cycle with a=0x12, b=0x34 -> sum=0x46, cout=0, prior result held until that DONE.
- Start held high through ADD while a/b change to 0x55/0x55 mid-operation (first operands a=0x0F, b=0x01) -> exactly one done; result 0x10, cout=0; the next op starts only after IDLE is re-entered.
- Assert rst asynchronously (mid-cycle) at bit 4 of an add -> busy, done, sum and cout go to 0 immediately; no done pulse; a following add of 0x03+0x04 returns 0x07.
- WIDTH=2: all 16 {a,b} pairs applied sequentially, each checked against a+b -> {cout,sum} == a+b for every pair.
